// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: branch codes,
// controller states and default counter width.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    BRANCH_NOP = 3'd0,
    BRANCH_EQ  = 3'd1,
    BRANCH_NEQ = 3'd2,
    BRANCH_LTZ = 3'd3,
    BRANCH_GTZ = 3'd4
  } branch_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = pipeline_hazard_ctrl_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencing controller: branch redirect via a registered
// target, load-use bubbles, memory-busy freeze and saturating event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_taken,
  input  logic [2:0]        branch_control,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              id_ex_mem_read,
  input  logic [REG_W-1:0]  id_ex_rt,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              mem_busy,
  input  logic              cnt_clear,
  output logic              pc_write,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic [CNT_W-1:0]  cnt_branches,
  output logic [CNT_W-1:0]  cnt_taken,
  output logic [CNT_W-1:0]  cnt_stalls
);

  state_e            state, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              load_use;
  logic              inc_branch, inc_taken, inc_stall;

  assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) ||
                     (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  assign pc_target = tgt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      tgt_q <= '0;
    end else begin
      state <= state_d;
      tgt_q <= tgt_d;
    end
  end

  always_comb begin
    state_d      = state;
    tgt_d        = tgt_q;
    pc_write     = 1'b0;
    pc_load      = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    inc_branch   = 1'b0;
    inc_taken    = 1'b0;
    inc_stall    = 1'b0;

    if (!rst_n) begin
      state_d = ST_RUN;
    end else if (mem_busy) begin
      // EX and ID re-present next cycle, so only the stall is recorded
      inc_stall = 1'b1;
    end else if (state == ST_REDIRECT) begin
      pc_write     = 1'b1;
      pc_load      = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      state_d      = ST_RUN;
    end else begin
      inc_branch = (branch_control != BRANCH_NOP);
      if (branch_taken) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_write = 1'b1;
        tgt_d        = branch_target;
        state_d      = ST_REDIRECT;
        inc_taken    = 1'b1;
      end else if (load_use) begin
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_write = 1'b1;
        inc_stall    = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_branches (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_branch),
    .clr   (cnt_clear),
    .cnt   (cnt_branches)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_taken),
    .clr   (cnt_clear),
    .cnt   (cnt_taken)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_stalls (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_stall),
    .clr   (cnt_clear),
    .cnt   (cnt_stalls)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS pipeline.
- Consumes the EX-stage branch decision (branch_taken, branch_control) and ID/EX load information.
- Generates PC and pipeline-register write enables and flushes: branch redirect with a registered target, load-use bubble insertion, and full freeze on memory busy.
- Keeps saturating performance counters for branches, taken branches and stall cycles.

Parameters:
- ADDR_W, 32, width of PC / branch target.
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- branch_taken  in  1  EX-stage branch decision.
- branch_control  in  3  EX-stage branch code (BRANCH_NOP, EQ, NEQ, LTZ, GTZ).
- branch_target  in  ADDR_W  EX-stage computed target.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  REG_W  destination of that load.
- if_id_rs  in  REG_W  rs of instruction in ID.
- if_id_rt  in  REG_W  rt of instruction in ID.
- if_id_uses_rt  in  1  ID instruction reads rt as a source.
- mem_busy  in  1  instruction/data memory not ready; freeze request.
- cnt_clear  in  1  synchronous clear of all counters.
- pc_write  out  1  PC register enable.
- pc_load  out  1  PC takes pc_target instead of PC+4.
- pc_target  out  ADDR_W  registered redirect address.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  IF/ID loads bubble.
- id_ex_write  out  1  ID/EX enable.
- id_ex_flush  out  1  ID/EX loads bubble.
- ex_mem_write  out  1  EX/MEM and MEM/WB enable.
- cnt_branches  out  CNT_W  resolved branches (branch_control != NOP).
- cnt_taken  out  CNT_W  taken branches accepted.
- cnt_stalls  out  CNT_W  freeze cycles plus load-use bubble cycles.

Behaviour:
- FSM states: RUN, REDIRECT. Registers: state, tgt_q (ADDR_W), three counters.
- Reset (rst_n low at edge): state=RUN, tgt_q=0, counters=0.
- While rst_n is low, all enables and flushes are 0, pc_load=0, pc_target=tgt_q.
- Per-cycle priority, highest first: freeze > REDIRECT action > branch accept > load-use > normal.
- Freeze (mem_busy=1, any state): all *_write=0, flushes=0, pc_load=0. State and tgt_q hold. cnt_stalls+1. No branch or load-use event is recorded, because EX and ID are frozen and re-present next cycle.
- RUN, branch_taken=1: pc_write=1, pc_load=0, if_id_flush=1, id_ex_flush=1, all writes=1. tgt_q<=branch_target. State->REDIRECT. cnt_taken+1.
- Branch accept squashes any coincident load-use stall, so no stall is counted.
- REDIRECT: pc_load=1, pc_write=1, pc_target=tgt_q, if_id_flush=1 (squashes wrong-path fetch), id_ex_flush=0. State->RUN.
- In REDIRECT, branch_taken and load-use are ignored; EX and ID hold bubbles.
- Total taken-branch penalty: 3 slots.
- RUN, load-use: id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==if_id_rs || (if_id_uses_rt && id_ex_rt==if_id_rt)).
  - Response: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1. cnt_stalls+1.
  - Repeats each cycle the condition holds; it self-clears after one bubble.
- Normal: all writes=1, flushes=0, pc_load=0.
- cnt_branches +1 in any non-frozen RUN cycle with branch_control != BRANCH_NOP, counted once per instruction.
- Counters saturate at all-ones and never wrap.
- cnt_clear=1 zeroes all counters and overrides any increment in the same cycle.
- Reset mid-REDIRECT: the redirect is dropped and state returns to RUN.

Decomposition:
- Shared package holds:
  - BRANCH_NOP/EQ/NEQ/LTZ/GTZ codes, the same definitions the branch decision block uses.
  - Controller state encodings ST_RUN, ST_REDIRECT.
  - Default CNT_W.
- One sub-module: sat_counter (CNT_W wide, inc, clr, rst_n; saturating), instantiated three times.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with branch_taken=1 -> all enables 0, counters 0. First cycle after release with no hazards -> all writes=1, flushes=0.
- Taken branch: RUN, branch_control=EQ, branch_taken=1, branch_target=0x0000_0040.
  - Cycle t: if_id_flush=id_ex_flush=1, pc_load=0.
  - Cycle t+1: pc_load=1, pc_target=0x40, if_id_flush=1.
  - Cycle t+2: normal. cnt_branches=1, cnt_taken=1.
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1, cnt_stalls=1.
- Load-use to $0: id_ex_rt=0, if_id_rs=0 -> no stall, cnt_stalls unchanged.
- Freeze during REDIRECT: enter REDIRECT (target 0x100), mem_busy=1 for 3 cycles -> outputs all 0, cnt_stalls=3. After busy clears, one cycle with pc_load=1, pc_target=0x100.
- Branch+load-use coincident; counters saturate and clear:
  - Branch plus load-use in the same cycle -> branch flush only, cnt_stalls unchanged.
  - Force 2^CNT_W+5 stall cycles -> cnt_stalls=0xFFFF.
  - cnt_clear with mem_busy=1 -> cnt_stalls=0 next cycle.
